zmod_tx_gearbox: RTL and testbench



---
 rtl/zmod_tx_pkg.sv | 26 ++
 rtl/zmod_sync2.sv | 24 ++
 rtl/zmod_tx_gearbox.sv | 146 ++++++++++++++
 tb/tb_zmod_tx_gearbox.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zmod_tx_pkg.sv
// Shared types and sample-format helpers for the Zmod DAC transmit path.
package zmod_tx_pkg;

  localparam int SAMPLE_W_DEF = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    RUN   = 2'd2
  } link_state_t;

  // Two's complement -> DAC code; only the top bit of a w-bit sample changes.
  function automatic logic [31:0] to_dac(input logic [31:0] sample, input int w,
                                         input bit offset_binary);
    logic [31:0] mask;
    mask = 32'd0;
    if (offset_binary) mask[w-1] = 1'b1;
    return sample ^ mask;
  endfunction

  // Midscale code of one sample slot; the idle word repeats it in every slot.
  function automatic logic [31:0] idle_word(input int w, input bit offset_binary);
    return to_dac(32'd0, w, offset_binary);
  endfunction

endpackage

// File: rtl/zmod_sync2.sv
// Two-flop synchronizer for a single level signal, resets to 0.
module zmod_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/zmod_tx_gearbox.sv
// Zmod DAC transmit gearbox: beat FIFO, lock-gated IDLE/TRAIN/RUN sequencer
// and registered 4-sample word toward the OSERDES lanes.
module zmod_tx_gearbox
  import zmod_tx_pkg::*;
#(
  parameter int                   SAMPLE_W      = SAMPLE_W_DEF,
  parameter int                   FIFO_DEPTH    = 8,
  parameter int                   TRAIN_CYCLES  = 256,
  parameter logic [SAMPLE_W-1:0]  TRAIN_A       = SAMPLE_W'(14'h2AAA),
  parameter logic [SAMPLE_W-1:0]  TRAIN_B       = SAMPLE_W'(14'h1555),
  parameter bit                   OFFSET_BINARY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic [4*SAMPLE_W-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [4*SAMPLE_W-1:0] out_data,
  output logic                  out_valid,
  output logic [1:0]            link_state,
  output logic [15:0]           underflow_cnt,
  input  logic                  clr_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = 4 * SAMPLE_W;
  localparam int CW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
  localparam logic [SAMPLE_W-1:0] IDLE_S = SAMPLE_W'(idle_word(SAMPLE_W, OFFSET_BINARY));
  localparam logic [WW-1:0] IDLE_WORD  = {4{IDLE_S}};
  localparam logic [WW-1:0] TRAIN_WORD = {TRAIN_B, TRAIN_A, TRAIN_B, TRAIN_A};

  function automatic logic [WW-1:0] dac_word(input logic [WW-1:0] raw);
    logic [WW-1:0] w;
    for (int i = 0; i < 4; i++)
      w[i*SAMPLE_W +: SAMPLE_W] =
        SAMPLE_W'(to_dac(32'(raw[i*SAMPLE_W +: SAMPLE_W]), SAMPLE_W, OFFSET_BINARY));
    return w;
  endfunction

  logic              locked_s;
  link_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]     mem_q [FIFO_DEPTH];
  logic              tready_q, tready_d;
  logic [WW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       ucnt_q, ucnt_d;
  logic              empty, wr_en;

  zmod_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign wr_en = s_tvalid && tready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = IDLE_WORD;
    out_valid_d = 1'b0;
    ucnt_d      = ucnt_q;
    tready_d    = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;

    // Losing lock flushes the FIFO outright, overriding any write this cycle.
    if (!locked_s) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE:    begin
          state_d = TRAIN;
          cnt_d   = CW'(TRAIN_CYCLES - 1);
        end
        TRAIN:   begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = RUN;
      endcase
    end

    // Outputs follow the state being entered so all three stay aligned.
    case (state_d)
      TRAIN:   out_data_d = TRAIN_WORD;
      RUN:     begin
        if (!empty) begin
          out_data_d  = dac_word(mem_q[rd_ptr_q[AW-1:0]]);
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (ucnt_q != 16'hFFFF) begin
          ucnt_d = ucnt_q + 16'd1;
        end
      end
      default: out_data_d = IDLE_WORD;
    endcase

    if (clr_cnt) ucnt_d = 16'd0;

    tready_d = (state_d != IDLE) &&
               !((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tready_q    <= 1'b0;
      out_data_q  <= IDLE_WORD;
      out_valid_q <= 1'b0;
      ucnt_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tready_q    <= tready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ucnt_q      <= ucnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_tdata;
  end

  assign s_tready      = tready_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign link_state    = state_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_zmod_tx_gearbox.sv
// Bench for zmod_tx_gearbox: queue-based reference model, vector table and
// directed sequences for lock, training, underflow and reset corners.
module tb_zmod_tx_gearbox;

  localparam int DEPTH = 8;
  localparam int TC    = 256;
  localparam logic [55:0] IDLE_W  = {4{14'h2000}};
  localparam logic [55:0] TRAIN_W = {14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA};
  localparam logic [55:0] FLIP    = {4{14'h2000}};

  logic        clk = 1'b0;
  logic        rst_n, pll_locked, s_tvalid, clr_cnt;
  logic [55:0] s_tdata;
  logic        s_tready, out_valid;
  logic [55:0] out_data;
  logic [1:0]  link_state;
  logic [15:0] underflow_cnt;

  always #5 clk = ~clk;

  zmod_tx_gearbox dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .link_state    (link_state),
    .underflow_cnt (underflow_cnt),
    .clr_cnt       (clr_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: link phase, beat queue, lock-delay history.
  logic [55:0] mq[$];
  int          m_state;   // 0 idle, 1 train, 2 run
  int          m_train_n;
  bit          m_lk1, m_lk2, m_tready, m_valid;
  logic [55:0] m_out;
  int          m_ucnt;

  typedef struct {
    logic [55:0] din;
    logic [55:0] dout;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired at %0t", nm, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_train_n = 0;
    m_lk1 = 0; m_lk2 = 0; m_tready = 0;
    m_out = IDLE_W; m_valid = 0; m_ucnt = 0;
  endtask

  task automatic model_step();
    bit          wr;
    logic [55:0] beat;
    wr      = s_tvalid && m_tready;
    beat    = s_tdata;
    m_valid = 0;
    m_out   = IDLE_W;
    if (!m_lk2) begin
      m_state = 0;
      mq.delete();
    end else begin
      if (m_state == 0) begin
        m_state = 1; m_train_n = 1;
      end else if (m_state == 1) begin
        if (m_train_n == TC) m_state = 2;
        else m_train_n++;
      end
      if (m_state == 1) m_out = TRAIN_W;
      else if (m_state == 2) begin
        if (mq.size() > 0) begin
          m_out = mq.pop_front() ^ FLIP;
          m_valid = 1;
        end else if (m_ucnt < 65535) m_ucnt++;
      end
      if (wr) mq.push_back(beat);
    end
    if (clr_cnt) m_ucnt = 0;
    m_tready = (m_state != 0) && (mq.size() < DEPTH);
    m_lk2 = m_lk1;
    m_lk1 = pll_locked;
  endtask

  task automatic check_all();
    chk("out_data", 64'(out_data), 64'(m_out));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("link_state", 64'(link_state), 64'(m_state));
    chk("s_tready", 64'(s_tready), 64'(m_tready));
    chk("underflow_cnt", 64'(underflow_cnt), 64'(m_ucnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string nm);
    int b;
    b = budget;
    while (link_state != st && b > 0) begin
      tick();
      b--;
    end
    if (link_state != st) timeout_fail(nm);
  endtask

  function automatic logic [55:0] beat_of(input int k);
    return {14'(4*k+3), 14'(4*k+2), 14'(4*k+1), 14'(4*k)};
  endfunction

  initial begin
    int ntrain, nacc, budget;
    bit acc;

    vt[0] = '{{14'd3, 14'd2, 14'd1, 14'd0}, {14'h2003, 14'h2002, 14'h2001, 14'h2000}};
    vt[1] = '{{14'd7, 14'd6, 14'd5, 14'd4}, {14'h2007, 14'h2006, 14'h2005, 14'h2004}};
    vt[2] = '{{14'h3FFF, 14'h1FFF, 14'h2000, 14'h0000}, {14'h1FFF, 14'h3FFF, 14'h0000, 14'h2000}};
    vt[3] = '{{14'h1234, 14'h0ABC, 14'h3000, 14'h0FFF}, {14'h3234, 14'h2ABC, 14'h1000, 14'h2FFF}};

    rst_n = 0; pll_locked = 1; s_tvalid = 0; s_tdata = '0; clr_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", 64'(out_data), 64'(IDLE_W));
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_link_state", 64'(link_state), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_underflow", 64'(underflow_cnt), 64'd0);
    #2 rst_n = 1;

    tick(); tick();
    chk("idle_two_cycles", 64'(link_state), 64'd0);
    tick();
    chk("enter_train", 64'(link_state), 64'd1);

    // Fill the FIFO during training; only DEPTH beats may get in.
    ntrain = 1; nacc = 0; budget = 1000;
    s_tvalid = 1; s_tdata = beat_of(0);
    while (link_state == 2'd1 && budget > 0) begin
      chk("train_word", 64'(out_data), 64'(TRAIN_W));
      if (ntrain == 200) chk("train_full_tready", 64'(s_tready), 64'd0);
      acc = s_tvalid && s_tready;
      tick();
      if (acc) begin
        nacc++;
        s_tdata = beat_of(nacc);
      end
      if (link_state == 2'd1) ntrain++;
      budget--;
    end
    if (budget == 0) timeout_fail("train_exit");
    s_tvalid = 0;
    chk("train_len", 64'(ntrain), 64'(TC));
    chk("train_accepts", 64'(nacc), 64'd8);
    chk("run_state", 64'(link_state), 64'd2);
    chk("drain_0", 64'(out_data), 64'(beat_of(0) ^ FLIP));
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("drain_k", 64'(out_data), 64'(beat_of(k) ^ FLIP));
    end
    tick();
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Vector table pushed back to back; each word appears two cycles later.
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        s_tvalid = 1; s_tdata = vt[i].din;
      end else s_tvalid = 0;
      tick();
      if (i == 0) chk("lat_not_yet", 64'(out_valid), 64'd0);
      else begin
        chk("vec_out", 64'(out_data), 64'(vt[i-1].dout));
        chk("vec_valid", 64'(out_valid), 64'd1);
      end
    end
    s_tvalid = 0;

    clr_cnt = 1; tick(); clr_cnt = 0;
    chk("clr_with_inc", 64'(underflow_cnt), 64'd0);
    repeat (10) tick();
    chk("underflow_10", 64'(underflow_cnt), 64'd10);
    chk("underflow_idle", 64'(out_data), 64'(IDLE_W));
    clr_cnt = 1; tick(); clr_cnt = 0;
    chk("clr_pulse", 64'(underflow_cnt), 64'd0);
    repeat (65540) tick();
    chk("underflow_sat", 64'(underflow_cnt), 64'hFFFF);
    clr_cnt = 1; tick(); clr_cnt = 0;

    // Lock loss with beats parked in the FIFO, then relock.
    pll_locked = 0;
    wait_state(2'd0, 10, "unlock_idle");
    pll_locked = 1;
    wait_state(2'd1, 10, "relock_train");
    nacc = 0; budget = 50; s_tvalid = 1; s_tdata = beat_of(100);
    while (nacc < 5 && budget > 0) begin
      acc = s_tvalid && s_tready;
      tick();
      if (acc) begin
        nacc++;
        s_tdata = beat_of(100 + nacc);
      end
      budget--;
    end
    if (nacc < 5) timeout_fail("park_beats");
    s_tvalid = 0;
    pll_locked = 0;
    wait_state(2'd0, 10, "drop_idle");
    chk("drop_tready", 64'(s_tready), 64'd0);
    chk("drop_out", 64'(out_data), 64'(IDLE_W));
    pll_locked = 1;
    wait_state(2'd1, 10, "relock2_train");
    ntrain = 0; budget = 1000;
    while (link_state == 2'd1 && budget > 0) begin
      ntrain++;
      tick();
      budget--;
    end
    if (budget == 0) timeout_fail("relock2_run");
    chk("relock_train_len", 64'(ntrain), 64'(TC));
    for (int i = 0; i < 5; i++) begin
      chk("no_stale", 64'(out_valid), 64'd0);
      tick();
    end

    // Randomized traffic with occasional lock drops and counter clears.
    for (int i = 0; i < 3000; i++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = 56'({$urandom(), $urandom()});
      clr_cnt  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) pll_locked = ~pll_locked;
      tick();
    end
    s_tvalid = 0; clr_cnt = 0; pll_locked = 1;
    wait_state(2'd2, 600, "pre_reset_run");

    // Asynchronous reset between clock edges while running.
    s_tvalid = 1; s_tdata = beat_of(7);
    tick(); tick();
    s_tvalid = 0;
    #3 rst_n = 0;
    #1;
    chk("arst_out_data", 64'(out_data), 64'(IDLE_W));
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_link_state", 64'(link_state), 64'd0);
    chk("arst_s_tready", 64'(s_tready), 64'd0);
    chk("arst_underflow", 64'(underflow_cnt), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1;
    wait_state(2'd1, 10, "post_reset_train");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
